// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD bus mode encodings, reader FSM states and default HD44780 timing constants.
package lcd_pkg;
  typedef enum logic [1:0] {
    MODE_STATUS = 2'b00,
    MODE_DATA   = 2'b01,
    MODE_POLL   = 2'b10,
    MODE_RSVD   = 2'b11
  } lcd_mode_e;
  typedef enum logic [2:0] {IDLE, SETUP, E_HI, HOLD, GAP, DONE} lcd_state_e;
  localparam int T_AS_DEF = 3;
  localparam int T_PW_DEF = 25;
  localparam int T_AH_DEF = 2;
  localparam int T_CYC_DEF = 50;
  localparam logic [15:0] POLL_MAX_DEF = 16'd50000;
endpackage

// File: rtl/lcd_reader_if.sv
// lcd_reader_if: request/acknowledge handshake between the LCD writer FSM (master) and lcd_reader (slave).
//   req/mode: start a read of the given mode; busy/done/rdata/timeout: transaction status and result.
interface lcd_reader_if;
  logic       req;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       timeout;
  modport master(output req, mode, input busy, done, rdata, timeout);
  modport slave(input req, mode, output busy, done, rdata, timeout);
endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous bus.
//   clk, rst_n (async active-low), i_d: async input, o_q: synchronized output.
module sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta, r_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end
  assign o_q = r_q;
endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: HD44780 read-cycle engine returning busy flag/address or RAM data, with busy-flag polling.
//   clk_50MHZ, reset (async active-low), bus: req/mode in, busy/done/rdata/timeout out,
//   own_bus/LCD_RS/LCD_RW/LCD_E: LCD control while owning the bus, DATA_BUS: LCD data pins (input only).
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int          T_AS     = T_AS_DEF,
  parameter int          T_PW     = T_PW_DEF,
  parameter int          T_AH     = T_AH_DEF,
  parameter int          T_CYC    = T_CYC_DEF,
  parameter logic [15:0] POLL_MAX = POLL_MAX_DEF
) (
  input  logic         clk_50MHZ,
  input  logic         reset,
  lcd_reader_if.slave  bus,
  output logic         own_bus,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic         LCD_E,
  input  logic [7:0]   DATA_BUS
);
  localparam int W = $clog2(T_CYC);
  // GAP pads each poll iteration so consecutive E rises are exactly T_CYC apart
  localparam int T_GAP = T_CYC - T_AS - T_PW - T_AH;
  lcd_state_e  r_state;
  lcd_mode_e   r_mode;
  logic [W-1:0] r_phase;
  logic [15:0] r_poll;
  logic [7:0]  r_sample, r_rdata;
  logic        r_armed, r_busy, r_done, r_timeout, r_own, r_rs, r_rw, r_e;
  logic [7:0]  w_sync;
  logic [15:0] w_cnt;
  logic        w_last, w_poll;
  sync2 #(.W(8)) u_sync (.clk(clk_50MHZ), .rst_n(reset), .i_d(DATA_BUS), .o_q(w_sync));
  assign w_last = r_phase == '0;
  assign w_poll = r_mode == MODE_POLL;
  assign w_cnt  = (r_poll == POLL_MAX) ? r_poll : r_poll + 16'd1;
  // r_armed blocks a req seen on the very first edge after reset release
  always_ff @(posedge clk_50MHZ or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_mode    <= MODE_STATUS;
      r_phase   <= '0;
      r_poll    <= '0;
      r_sample  <= '0;
      r_rdata   <= '0;
      r_armed   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_own     <= 1'b0;
      r_rs      <= 1'b0;
      r_rw      <= 1'b0;
      r_e       <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_done  <= 1'b0;
      r_phase <= r_phase - 1'b1;
      case (r_state)
        IDLE: if (bus.req && r_armed) begin
          r_state <= SETUP;
          r_mode  <= lcd_mode_e'(bus.mode);
          r_rs    <= bus.mode == MODE_DATA;
          r_rw    <= 1'b1;
          r_own   <= 1'b1;
          r_busy  <= 1'b1;
          r_poll  <= '0;
          r_phase <= W'(T_AS - 1);
        end
        SETUP: if (w_last) begin
          r_state <= E_HI;
          r_e     <= 1'b1;
          r_phase <= W'(T_PW - 1);
        end
        E_HI: if (w_last) begin
          r_state  <= HOLD;
          r_e      <= 1'b0;
          r_sample <= w_sync;
          r_phase  <= W'(T_AH - 1);
        end
        HOLD: if (w_last) begin
          if (w_poll) r_poll <= w_cnt;
          if (w_poll && r_sample[7] && w_cnt < POLL_MAX) begin
            r_state <= GAP;
            r_phase <= W'(T_GAP - 1);
          end else begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_own     <= 1'b0;
            r_rs      <= 1'b0;
            r_rw      <= 1'b0;
            r_rdata   <= r_sample;
            r_timeout <= w_poll && r_sample[7];
          end
        end
        GAP: if (w_last) begin
          r_state <= SETUP;
          r_phase <= W'(T_AS - 1);
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rdata   = r_rdata;
  assign bus.timeout = r_timeout;
  assign own_bus     = r_own;
  assign LCD_RS      = r_rs;
  assign LCD_RW      = r_rw;
  assign LCD_E       = r_e;
endmodule
